// File: rtl/gfx256_zbuffer_test.sv
// Depth-test stage: reads the stored 16-bit depth for (x, y), and on a strict
// greater-than pass writes the new depth back and forwards the fragment downstream.
module gfx256_zbuffer_test #(
  parameter int unsigned point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [31:0]            zbuffer_base_i,
  input  logic [point_width-1:0] target_width_i,
  input  logic                   write_i,
  output logic                   ack_o,
  input  logic [point_width-1:0] x_i,
  input  logic [point_width-1:0] y_i,
  input  logic [point_width-1:0] z_i,
  input  logic [31:0]            color_i,
  input  logic [7:0]             a_i,
  output logic                   zr_request_o,
  output logic [31:0]            zr_addr_o,
  input  logic [31:0]            zr_data_i,
  input  logic                   zr_ack_i,
  output logic                   zw_request_o,
  output logic [31:0]            zw_addr_o,
  output logic [31:0]            zw_data_o,
  output logic [3:0]             zw_sel_o,
  input  logic                   zw_ack_i,
  output logic                   write_o,
  input  logic                   ack_i,
  output logic [point_width-1:0] x_o,
  output logic [point_width-1:0] y_o,
  output logic [31:0]            color_o,
  output logic [7:0]             a_o
);

  typedef enum logic [2:0] {IDLE, READ, TEST, WRITE, OUT} state_t;

  state_t                 state;
  logic [point_width-1:0] z_q;
  logic [point_width-1:0] stored_q;
  logic                   hw_q;

  logic [31:0]            off_c;
  logic [31:0]            byte_c;
  logic [point_width-1:0] half_c;
  logic                   pass_c;
  logic                   unused_byte_lsb;

  // Pixel offset in words of 16 bits, turned into a byte address.
  assign off_c  = 32'(y_i) * 32'(target_width_i) + 32'(x_i);
  assign byte_c = zbuffer_base_i + (off_c << 1);
  assign unused_byte_lsb = byte_c[0];

  assign half_c = hw_q ? point_width'(zr_data_i[31:16]) : point_width'(zr_data_i[15:0]);
  assign pass_c = $signed(z_q) > $signed(stored_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      z_q          <= '0;
      stored_q     <= '0;
      hw_q         <= 1'b0;
      ack_o        <= 1'b0;
      zr_request_o <= 1'b0;
      zr_addr_o    <= '0;
      zw_request_o <= 1'b0;
      zw_addr_o    <= '0;
      zw_data_o    <= '0;
      zw_sel_o     <= '0;
      write_o      <= 1'b0;
      x_o          <= '0;
      y_o          <= '0;
      color_o      <= '0;
      a_o          <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        IDLE: begin
          // ack_o high means write_i still belongs to the fragment just retired.
          if (write_i && !ack_o) begin
            x_o       <= x_i;
            y_o       <= y_i;
            z_q       <= z_i;
            color_o   <= color_i;
            a_o       <= a_i;
            zr_addr_o <= {byte_c[31:2], 2'b00};
            zw_addr_o <= {byte_c[31:2], 2'b00};
            hw_q      <= byte_c[1];
            if (enable_i) begin
              zr_request_o <= 1'b1;
              state        <= READ;
            end else begin
              write_o <= 1'b1;
              state   <= OUT;
            end
          end
        end
        READ: begin
          if (zr_ack_i) begin
            stored_q     <= half_c;
            zr_request_o <= 1'b0;
            state        <= TEST;
          end
        end
        TEST: begin
          if (pass_c) begin
            zw_request_o <= 1'b1;
            zw_data_o    <= 32'({z_q, z_q});
            zw_sel_o     <= hw_q ? 4'b1100 : 4'b0011;
            state        <= WRITE;
          end else begin
            ack_o <= 1'b1;
            state <= IDLE;
          end
        end
        WRITE: begin
          if (zw_ack_i) begin
            zw_request_o <= 1'b0;
            write_o      <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (ack_i) begin
            write_o <= 1'b0;
            ack_o   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_zbuffer_test.sv
// Randomized bench for gfx256_zbuffer_test: memory and downstream responders
// with random wait states, checked against an address/depth-test reference model.
module tb_gfx256_zbuffer_test;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [31:0] zbuffer_base_i;
  logic [15:0] target_width_i;
  logic        write_i;
  logic        ack_o;
  logic [15:0] x_i, y_i, z_i;
  logic [31:0] color_i;
  logic [7:0]  a_i;
  logic        zr_request_o;
  logic [31:0] zr_addr_o;
  logic [31:0] zr_data_i;
  logic        zr_ack_i;
  logic        zw_request_o;
  logic [31:0] zw_addr_o;
  logic [31:0] zw_data_o;
  logic [3:0]  zw_sel_o;
  logic        zw_ack_i;
  logic        write_o;
  logic        ack_i;
  logic [15:0] x_o, y_o;
  logic [31:0] color_o;
  logic [7:0]  a_o;

  int checks = 0;
  int errors = 0;

  gfx256_zbuffer_test #(.point_width(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .zbuffer_base_i(zbuffer_base_i), .target_width_i(target_width_i),
    .write_i(write_i), .ack_o(ack_o),
    .x_i(x_i), .y_i(y_i), .z_i(z_i), .color_i(color_i), .a_i(a_i),
    .zr_request_o(zr_request_o), .zr_addr_o(zr_addr_o), .zr_data_i(zr_data_i), .zr_ack_i(zr_ack_i),
    .zw_request_o(zw_request_o), .zw_addr_o(zw_addr_o), .zw_data_o(zw_data_o),
    .zw_sel_o(zw_sel_o), .zw_ack_i(zw_ack_i),
    .write_o(write_o), .ack_i(ack_i),
    .x_o(x_o), .y_o(y_o), .color_o(color_o), .a_o(a_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return {ack_o, zr_request_o, zr_addr_o, zw_request_o, zw_addr_o, zw_data_o, zw_sel_o,
            write_o, x_o, y_o, color_o, a_o};
  endfunction

  // One fragment through the DUT; the memory returns rdata after rw waits,
  // the write ack comes after ww waits and downstream accepts after dw waits.
  task automatic run_frag(input logic en, input logic [31:0] base, input logic [15:0] w,
                          input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input logic [31:0] col, input logic [7:0] a, input logic [31:0] rdata,
                          input int rw, input int ww, input int dw, input string tag);
    logic [31:0] off, byt, exp_addr;
    logic [15:0] stored;
    logic        hw, pass;
    int rcnt = 0, wcnt = 0, dcnt = 0, acks = 0;
    bit saw_r = 0, saw_w = 0, saw_o = 0, both = 0, bad_r = 0, bad_w = 0, bad_o = 0, req_at_ack = 0;
    bit done = 0;

    off      = 32'(y) * 32'(w) + 32'(x);
    byt      = base + (off << 1);
    exp_addr = byt & 32'hFFFF_FFFC;
    hw       = byt[1];
    stored   = hw ? rdata[31:16] : rdata[15:0];
    pass     = !en || ($signed(z) > $signed(stored));

    @(negedge clk_i);
    enable_i = en; zbuffer_base_i = base; target_width_i = w;
    x_i = x; y_i = y; z_i = z; color_i = col; a_i = a; zr_data_i = rdata;
    write_i = 1'b1;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk_i);
      // Scramble the capture-time inputs once the fragment is in flight.
      if (cyc == 1) begin
        enable_i = ~en; zbuffer_base_i = $urandom; target_width_i = 16'($urandom);
      end
      if (zr_request_o && zw_request_o) both = 1;
      if (zr_request_o) begin
        saw_r = 1; rcnt++;
        if (zr_addr_o !== exp_addr) bad_r = 1;
        zr_ack_i = (rcnt > rw);
      end else zr_ack_i = 1'b0;
      if (zw_request_o) begin
        saw_w = 1; wcnt++;
        if (zw_addr_o !== exp_addr || zw_data_o !== {z, z} ||
            zw_sel_o !== (hw ? 4'b1100 : 4'b0011)) bad_w = 1;
        zw_ack_i = (wcnt > ww);
      end else zw_ack_i = 1'b0;
      if (write_o) begin
        saw_o = 1; dcnt++;
        if (x_o !== x || y_o !== y || color_o !== col || a_o !== a) bad_o = 1;
        ack_i = (dcnt > dw);
      end else ack_i = 1'b0;
      if (ack_o) begin
        acks++;
        if (zr_request_o || zw_request_o || write_o) req_at_ack = 1;
        done = 1;
      end
    end
    check_eq({tag, "_timeout"}, 64'(done), 64'd1);

    // write_i is still held through the ack cycle: it must not be re-captured.
    zr_ack_i = 1'b0; zw_ack_i = 1'b0; ack_i = 1'b0;
    @(negedge clk_i);
    check_eq({tag, "_ack_width_no_recapture"},
             64'({ack_o, zr_request_o, zw_request_o, write_o}), 64'd0);
    write_i = 1'b0;

    check_eq({tag, "_acks"}, 64'(acks), 64'd1);
    check_eq({tag, "_read_seen"}, 64'(saw_r), 64'(en));
    check_eq({tag, "_write_seen"}, 64'(saw_w), 64'(en && pass));
    check_eq({tag, "_out_seen"}, 64'(saw_o), 64'(pass));
    check_eq({tag, "_bad_fields"}, 64'({bad_r, bad_w, bad_o, both, req_at_ack}), 64'd0);
  endtask

  initial begin
    logic [31:0] held_addr;
    bit moved;
    rst_ni = 1'b0; enable_i = 0; zbuffer_base_i = '0; target_width_i = '0;
    write_i = 1'b1; x_i = 16'h1; y_i = 16'h1; z_i = 16'h7fff; color_i = '1; a_i = '1;
    zr_data_i = '0; zr_ack_i = 0; zw_ack_i = 0; ack_i = 0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("reset_outputs", 64'(all_outputs() != 128'd0), 64'd0);
    write_i = 1'b0;
    rst_ni  = 1'b1;

    run_frag(1'b0, 32'h0, 16'd640, 16'd5, 16'd7, 16'h0, 32'h00AABBCC, 8'h11, 32'h0, 0, 0, 0, "bypass");
    run_frag(1'b1, 32'h1000, 16'd640, 16'd2, 16'd1, 16'h0100, 32'h12345678, 8'h22,
             32'hDEAD0080, 0, 0, 0, "pass_low");
    run_frag(1'b1, 32'h1000, 16'd640, 16'd3, 16'd1, 16'hFFFF, 32'h0BADF00D, 8'h33,
             32'h80007FFF, 1, 2, 1, "pass_high");
    run_frag(1'b1, 32'h1000, 16'd640, 16'd2, 16'd1, 16'h0100, 32'h55AA5555, 8'h44,
             32'hFFFF0100, 0, 0, 0, "fail_equal");
    run_frag(1'b1, 32'hFFFF_FFF0, 16'd100, 16'd50, 16'd0, 16'h7FFF, 32'h1, 8'h55,
             32'h8000_8000, 0, 0, 0, "addr_wrap");

    // Stall the read for 10 cycles, then reset mid-READ.
    @(negedge clk_i);
    enable_i = 1'b1; zbuffer_base_i = 32'h1000; target_width_i = 16'd640;
    x_i = 16'd3; y_i = 16'd1; z_i = 16'h0100; write_i = 1'b1;
    @(negedge clk_i);
    check_eq("stall_req_start", 64'(zr_request_o), 64'd1);
    held_addr = zr_addr_o;
    check_eq("stall_addr", 64'(held_addr), 64'h1504);
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!zr_request_o || zr_addr_o !== held_addr) moved = 1;
    end
    check_eq("stall_held_stable", 64'(moved), 64'd0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_eq("reset_mid_read", 64'(all_outputs() != 128'd0), 64'd0);
    write_i = 1'b0; rst_ni = 1'b1;
    zr_ack_i = 1'b1;
    @(negedge clk_i);
    zr_ack_i = 1'b0;
    check_eq("idle_after_reset", 64'({zr_request_o, zw_request_o, ack_o, write_o}), 64'd0);

    for (int n = 0; n < 150; n++) begin
      logic [15:0] z, st;
      logic [31:0] rd;
      z  = 16'($urandom);
      st = ($urandom_range(0, 4) == 0) ? z : 16'($urandom);
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) rd[31:16] = st; else rd[15:0] = st;
      run_frag(1'($urandom_range(0, 3) != 0), $urandom, 16'($urandom_range(1, 2048)),
               16'($urandom_range(0, 2047)), 16'($urandom_range(0, 2047)), z, $urandom,
               8'($urandom), rd, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
